// File: rtl/seg_pattern_reader.sv
// Reads back a 7-bit active-low seven-segment bus as a hex digit.
// The pattern must hold steady before it is decoded, and each newly shown digit is presented once on a valid/ready register.
module seg_pattern_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] HEX,
  output logic [3:0] digit,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    EMIT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       BLANK      = 7'h7F;

  state_t           state;
  state_t           state_next;
  logic [6:0]       seg_meta;
  logic [6:0]       seg_s;
  logic [6:0]       seg_q;
  logic [6:0]       last_accepted;
  logic [CNT_W-1:0] stable_cnt;
  logic             seg_same;
  logic             stable_hit;
  logic             accept;
  logic             glyph_ok;
  logic [3:0]       glyph_val;
  logic             is_blank;
  logic             emit;
  logic             take;

  // Two-flop synchronizer. Both flops reset to blank so nothing is lit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_meta <= BLANK;
      seg_s    <= BLANK;
    end else begin
      seg_meta <= HEX;
      seg_s    <= seg_meta;
    end
  end

  assign seg_same = (seg_s == seg_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_q      <= BLANK;
      stable_cnt <= '0;
    end else begin
      seg_q <= seg_s;
      if (!seg_same) begin
        stable_cnt <= '0;
      end else if (stable_cnt != STABLE_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  // Stability counts as reached on the edge where the counter reaches STABLE_CYCLES.
  assign stable_hit = seg_same && (stable_cnt >= STABLE_PRE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      SETTLE: begin
        if (stable_hit) begin
          if (seg_s != last_accepted) begin
            accept     = 1'b1;
            state_next = EMIT;
          end else begin
            state_next = LOCKED;
          end
        end
      end
      // A change arriving during EMIT would be missed by LOCKED, so re-settle on it.
      EMIT:    state_next = seg_same ? LOCKED : SETTLE;
      LOCKED:  if (!seg_same) state_next = SETTLE;
      default: state_next = SETTLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= SETTLE;
      last_accepted <= BLANK;
    end else begin
      state <= state_next;
      if (accept) last_accepted <= seg_s;
    end
  end

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    is_blank  = 1'b0;
    case (last_accepted)
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h10: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      7'h7F: begin
        glyph_ok = 1'b0;
        is_blank = 1'b1;
      end
      default: glyph_ok = 1'b0;
    endcase
  end

  // Handshake: a code transfers on any rising edge where out_valid & out_ready;
  // digit/out_err hold while out_valid=1 and out_ready=0, and a new code arriving
  // then is dropped and flagged in the sticky overflow bit.
  assign emit = (state == EMIT) && !is_blank;
  assign take = out_valid && out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit     <= 4'h0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (take) out_valid <= 1'b0;
      if (emit) begin
        if (out_valid && !out_ready) begin
          overflow <= 1'b1;
        end else begin
          digit     <= glyph_ok ? glyph_val : 4'h0;
          out_err   <= !glyph_ok;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Bench for seg_pattern_reader: drives segment patterns, scores emitted codes against an expected queue.
module tb_seg_pattern_reader;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [6:0] hex = 7'h7F;
  logic       out_ready = 1'b1;
  logic [3:0] digit;
  logic       out_err;
  logic       out_valid;
  logic       overflow;

  logic [4:0] exp_q[$];
  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int n_cmp = 0;
  int n_err = 0;
  int lat;

  seg_pattern_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .HEX       (hex),
    .digit     (digit),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller sits just after a rising edge; the pattern is held for `cycles` edges.
  task automatic show(input logic [6:0] p, input int cycles);
    hex = p;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  // Edge index (E0 = first edge after the change/release) at which out_valid rises.
  task automatic measure(output int l);
    l = -1;
    for (int i = 0; i < 20 && l < 0; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) l = i;
    end
  endtask

  task automatic pulse_reset_and_check(input string tag);
    resetn = 1'b0;
    #1;
    check_eq({tag, "_digit"}, digit, 0);
    check_eq({tag, "_err"}, out_err, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Scoreboard: every accepted transfer pops one expected {out_err, digit}.
  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      check_eq("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("code", {out_err, digit}, exp_q.pop_front());
    end
  end

  initial begin
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_digit", digit, 0);
    check_eq("rst_err", out_err, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ovf", overflow, 0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check_eq("blank_no_valid", out_valid, 0);

    // Single digit and first-valid latency
    exp_q.push_back({1'b0, 4'h2});
    hex = 7'h24;
    measure(lat);
    check_eq("latency_first", lat, 7);
    show(7'h24, 4);
    check_eq("ovf_after_first", overflow, 0);

    // Sweep of all legal glyphs, then blank, then an illegal pattern
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b0, 4'(i)});
      show(glyphs[i], 8);
    end
    show(7'h7F, 8);
    exp_q.push_back({1'b1, 4'h0});
    show(7'h55, 8);

    // Short glitch suppressed
    show(7'h79, 3);
    exp_q.push_back({1'b0, 4'h3});
    show(7'h30, 8);

    // Re-display: one emit while held, a second after going blank and back
    exp_q.push_back({1'b0, 4'h5});
    show(7'h12, 20);
    show(7'h7F, 6);
    exp_q.push_back({1'b0, 4'h5});
    show(7'h12, 10);

    // Back-pressure overflow
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 4'h1});
    show(7'h79, 10);
    show(7'h24, 10);
    check_eq("ovf_digit_held", digit, 1);
    check_eq("ovf_valid_held", out_valid, 1);
    check_eq("ovf_set", overflow, 1);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq("ovf_consumed_valid", out_valid, 0);
    check_eq("ovf_sticky", overflow, 1);

    // Reset while a code is held; pattern at release emits after full latency
    out_ready = 1'b0;
    show(7'h40, 10);
    check_eq("held_before_rst", out_valid, 1);
    pulse_reset_and_check("rst_valid");
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 4'h0});
    measure(lat);
    check_eq("latency_rst_valid", lat, 7);
    show(7'h40, 4);

    // Reset while settling on a new pattern
    show(7'h19, 2);
    pulse_reset_and_check("rst_settle");
    exp_q.push_back({1'b0, 4'h4});
    measure(lat);
    check_eq("latency_rst_settle", lat, 7);
    show(7'h19, 6);

    check_eq("leftover", exp_q.size(), 0);
    check_eq("final_ovf", overflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_pattern_reader.md
Name: seg_pattern_reader

Overview:
- Inverse of the team's hex-to-seven-segment decoder: samples a 7-bit active-low segment bus, waits for it to settle, and recovers the 4-bit hex digit it shows.
- Presents each newly displayed digit once, on a valid/ready output register.
- Used on boards where a display bus driven by another unit (or the SW switches) must be read back as a digit.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the synchronized pattern must hold before it is accepted (range 1..255).
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clock  input  1  single system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- HEX  input  7  segment bus, active-low (0 = lit); bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- digit  output  4  recovered hex value.
- out_err  output  1  qualifies digit: accepted pattern was not a legal glyph.
- out_valid  output  1  digit/out_err hold a code not yet taken.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- overflow  output  1  sticky: a code was dropped; cleared only by reset.

Behaviour:
- Reset (asynchronous, resetn=0):
  - digit=0, out_err=0, out_valid=0, overflow=0.
  - Both synchronizer flops = 7'h7F; last_accepted = 7'h7F (blank); counter=0; state=SETTLE.
- Synchronizer: 2-flop on HEX; seg_s is the second flop output. All logic uses seg_s only.
- Stability tracking: register seg_q <= seg_s each cycle.
  - If seg_s != seg_q, counter <= 0.
  - Otherwise counter increments, saturating at STABLE_CYCLES.
- FSM states SETTLE, EMIT, LOCKED:
  - SETTLE: when counter == STABLE_CYCLES:
    - If seg_s != last_accepted: last_accepted <= seg_s, go to EMIT.
    - Else go to LOCKED, with no emit.
  - EMIT (exactly one cycle): classify last_accepted, then go to LOCKED.
    - Legal glyph: load digit, out_err=0, out_valid=1.
    - Blank 7'h7F: nothing loaded; no output and no error.
    - Any other pattern: load digit=0, out_err=1, out_valid=1.
  - LOCKED: if seg_s != seg_q, go to SETTLE (counter already restarting at 0).
  - A change during SETTLE restarts the count; glitches shorter than STABLE_CYCLES are never emitted.
- Glyph table (HEX[6:0], active-low):

      0=40  1=79  2=24  3=30  4=19  5=12  6=02  7=78
      8=00  9=10  A=08  b=03  C=46  d=21  E=06  F=0E

- Output register:
  - out_valid clears on the cycle where out_valid & out_ready.
  - digit and out_err hold while out_valid=1 and out_ready=0.
  - EMIT with out_valid=1 and out_ready=0 in that cycle: the new code is dropped, overflow <= 1, and the held code is unchanged.
  - EMIT in the same cycle as a handshake: the new code loads and out_valid stays 1 (no bubble, no overflow).
- Latency: an HEX change that meets setup before rising edge E0 gives out_valid=1 after edge E0+STABLE_CYCLES+3.
  - This is 7 edges at the default STABLE_CYCLES=4.
  - The pattern must stay constant throughout.
- Re-display: the same digit shown twice in a row emits once. Toggling to a different pattern (including blank) and back emits again.
- Reset asserted mid-operation: everything returns immediately to reset values. No partial or held code survives.

Test Plan:
- Reset, then HEX=7'h24 held 10 cycles, out_ready=1 -> single out_valid pulse with digit=2, out_err=0, first high 7 edges after the change; overflow=0.
- Sweep all 16 legal patterns, each held 8 cycles, out_ready=1 -> digits 0..F in order. Then HEX=7'h7F -> no output. Then HEX=7'h55 -> digit=0, out_err=1.
- HEX=7'h79 for 3 cycles, then 7'h30 for 8 cycles (STABLE_CYCLES=4) -> only digit=3 emitted; the 3-cycle glitch is suppressed.
- out_ready=0; show 1 (7'h79), then 2 (7'h24) -> digit stays 1 with out_valid=1 and overflow=1. Then out_ready=1 -> digit=1 consumed, out_valid=0, and overflow stays 1.
- Hold 7'h12 for 20 cycles -> exactly one emit (digit=5). Go to 7'h7F for 6 cycles, then back to 7'h12 -> a second emit of digit=5.
- Pull resetn low for 1 cycle while in SETTLE and again while out_valid=1 -> outputs 0 and overflow cleared immediately. A pattern present at release emits after full latency counted from the release.
